// File: rtl/pico_decoder_fsm.sv
// ---------------------------------------------------------------------------
// pico_decoder_fsm
//
// Instruction decoder and control FSM for a small accumulator-style CPU.
// Decodes the opcode from program memory into a registered control word
// (ALUFunc, PCincr, imm, imm_or_sw, write). It stalls in LDWAIT while a LOAD
// waits for switch data, and locks up in HALT on an unimplemented opcode.
//
// Opcode map (zero-extended to OPW bits):
//   NOP=0  ADDI=1  ADD=2  MULI=3  LOAD=4   (anything else is illegal)
//
// Configuration macro:
//   PICO_MULI_EN  defined   -> MULI decodes like ADDI (immediate ALU op)
//                 undefined -> opcode 3 is illegal and drives the FSM to HALT
//
// Reset is synchronous and active-high. Every output comes from a flop, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module pico_decoder_fsm #(
    parameter int OPW  = 3,   // opcode width, 3..8
    parameter int ALUW = 2,   // ALUFunc width, 2..OPW
    parameter int CNTW = 16   // stall counter width
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            instr_valid,
    input  logic            sw_valid,
    output logic [ALUW-1:0] ALUFunc,
    output logic            PCincr,
    output logic            imm,
    output logic            imm_or_sw,
    output logic            write,
    output logic [1:0]      state,
    output logic            illegal,
    output logic [CNTW-1:0] stall_cnt
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_LDWAIT = 2'b01,
        ST_HALT   = 2'b10
    } state_t;

    // One control word, kept together so every decision assigns all fields.
    typedef struct packed {
        logic write;
        logic imm;
        logic imm_or_sw;
        logic pcincr;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
`ifdef PICO_MULI_EN
    localparam logic [OPW-1:0] OP_MULI = OPW'(3);
`endif
    localparam logic [OPW-1:0] OP_LOAD = OPW'(4);

    // Plain sequential fetch, no register write.
    localparam ctrl_t CTRL_DEFAULT = '{write: 1'b0, imm: 1'b0, imm_or_sw: 1'b0, pcincr: 1'b1};
    // Register-register ALU op.
    localparam ctrl_t CTRL_ADD     = '{write: 1'b1, imm: 1'b0, imm_or_sw: 1'b0, pcincr: 1'b1};
    // ALU op with the immediate field as second operand.
    localparam ctrl_t CTRL_IMM     = '{write: 1'b1, imm: 1'b1, imm_or_sw: 1'b1, pcincr: 1'b1};
    // Load from the switches (imm path selected, switch data muxed in).
    localparam ctrl_t CTRL_LOAD    = '{write: 1'b1, imm: 1'b1, imm_or_sw: 1'b0, pcincr: 1'b1};
    // Freeze the PC and suppress writes: LDWAIT, HALT and reset all use this.
    localparam ctrl_t CTRL_STALL   = '{write: 1'b0, imm: 1'b0, imm_or_sw: 1'b0, pcincr: 1'b0};

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    ctrl_t           ctrl_q,  ctrl_d;
    logic [ALUW-1:0] alu_q;
    logic            alu_load;
    logic            illegal_q, illegal_set;
    logic [CNTW-1:0] cnt_q;
    logic            cnt_inc;

    logic            is_nop;
    logic            is_add;
    logic            is_imm_alu;
    logic            is_load;

    // -----------------------------------------------------------------------
    // Opcode classification. Full-width compares, so any set bit above bit 2
    // makes the opcode fall through to illegal.
    // -----------------------------------------------------------------------
    assign is_nop  = (opcode == OP_NOP);
    assign is_add  = (opcode == OP_ADD);
    assign is_load = (opcode == OP_LOAD);
`ifdef PICO_MULI_EN
    assign is_imm_alu = (opcode == OP_ADDI) || (opcode == OP_MULI);
`else
    // Without the multiplier, opcode 3 is simply not recognised here.
    assign is_imm_alu = (opcode == OP_ADDI);
`endif

    // -----------------------------------------------------------------------
    // Next-state and next control word decision for the current cycle.
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statement, so no
    // path through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = CTRL_DEFAULT;
        alu_load    = 1'b0;
        illegal_set = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (instr_valid) begin
                    // ALUFunc follows every valid opcode seen in RUN,
                    // legal or not; it is ignored unless write is set.
                    alu_load = 1'b1;
                    if (is_nop) begin
                        ctrl_d = CTRL_DEFAULT;
                    end else if (is_add) begin
                        ctrl_d = CTRL_ADD;
                    end else if (is_imm_alu) begin
                        ctrl_d = CTRL_IMM;
                    end else if (is_load) begin
                        if (sw_valid) begin
                            ctrl_d = CTRL_LOAD;
                        end else begin
                            ctrl_d  = CTRL_STALL;
                            state_d = ST_LDWAIT;
                        end
                    end else begin
                        ctrl_d      = CTRL_STALL;
                        illegal_set = 1'b1;
                        state_d     = ST_HALT;
                    end
                end
            end

            ST_LDWAIT: begin
                // The LOAD is still pending; opcode and instr_valid are
                // ignored, only the switch strobe matters.
                if (sw_valid) begin
                    ctrl_d  = CTRL_LOAD;
                    state_d = ST_RUN;
                end else begin
                    ctrl_d  = CTRL_STALL;
                    cnt_inc = 1'b1;
                end
            end

            ST_HALT: begin
                ctrl_d = CTRL_STALL;
            end

            default: begin
                // Unused encoding 11: lock up rather than run on garbage.
                ctrl_d  = CTRL_STALL;
                state_d = ST_HALT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, control word, ALUFunc and sticky illegal flag registers.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            ctrl_q    <= CTRL_STALL;
            alu_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (alu_load) begin
                alu_q <= opcode[ALUW-1:0];
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Saturating count of LDWAIT stall cycles since reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, straight from the flops.
    // -----------------------------------------------------------------------
    assign ALUFunc   = alu_q;
    assign PCincr    = ctrl_q.pcincr;
    assign imm       = ctrl_q.imm;
    assign imm_or_sw = ctrl_q.imm_or_sw;
    assign write     = ctrl_q.write;
    assign state     = state_q;
    assign illegal   = illegal_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pico_decoder_fsm.sv
// ---------------------------------------------------------------------------
// tb_pico_decoder_fsm
//
// Directed bench for pico_decoder_fsm. Two instances share all inputs: the
// default build (CNTW=16) and a narrow-counter build (CNTW=2) used to check
// counter saturation. Inputs change #1 after a rising edge; outputs are
// checked #1 after the following rising edge. Honours PICO_MULI_EN for the
// expected MULI behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pico_decoder_fsm;

    localparam int OPW  = 3;
    localparam int ALUW = 2;

    localparam int S_RUN    = 0;
    localparam int S_LDWAIT = 1;
    localparam int S_HALT   = 2;

    logic            clk;
    logic            reset;
    logic [OPW-1:0]  opcode;
    logic            instr_valid;
    logic            sw_valid;

    logic [ALUW-1:0] alu_a;
    logic            pc_a, imm_a, ios_a, wr_a, ill_a;
    logic [1:0]      st_a;
    logic [15:0]     cnt_a;

    logic [ALUW-1:0] alu_b;
    logic            pc_b, imm_b, ios_b, wr_b, ill_b;
    logic [1:0]      st_b;
    logic [1:0]      cnt_b;

    int tests_run;
    int tests_failed;

    pico_decoder_fsm #(.OPW(OPW), .ALUW(ALUW), .CNTW(16)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .sw_valid   (sw_valid),
        .ALUFunc    (alu_a),
        .PCincr     (pc_a),
        .imm        (imm_a),
        .imm_or_sw  (ios_a),
        .write      (wr_a),
        .state      (st_a),
        .illegal    (ill_a),
        .stall_cnt  (cnt_a)
    );

    pico_decoder_fsm #(.OPW(OPW), .ALUW(ALUW), .CNTW(2)) u_small (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .sw_valid   (sw_valid),
        .ALUFunc    (alu_b),
        .PCincr     (pc_b),
        .imm        (imm_b),
        .imm_or_sw  (ios_b),
        .write      (wr_b),
        .state      (st_b),
        .illegal    (ill_b),
        .stall_cnt  (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; returns #1 after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input bit iv, input bit sw);
        opcode      = OPW'(op);
        instr_valid = iv;
        sw_valid    = sw;
    endtask

    // Check the four control bits of the main instance in one call.
    task automatic check_word(input string tag, input int w, input int im,
                              input int ios, input int pc);
        check({tag, ".write"},     int'(wr_a),  w);
        check({tag, ".imm"},       int'(imm_a), im);
        check({tag, ".imm_or_sw"}, int'(ios_a), ios);
        check({tag, ".PCincr"},    int'(pc_a),  pc);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        drive(0, 1'b0, 1'b0);

        // ---- Reset state ----
        tick();
        tick();
        check_word("rst", 0, 0, 0, 0);
        check("rst.state",   int'(st_a),  S_RUN);
        check("rst.alu",     int'(alu_a), 0);
        check("rst.illegal", int'(ill_a), 0);
        check("rst.cnt",     int'(cnt_a), 0);

        // ---- Release reset, present ADD in the same cycle ----
        reset = 1'b0;
        drive(2, 1'b1, 1'b0);
        check("rel.PCincr_first", int'(pc_a), 0);
        tick();
        check_word("add", 1, 0, 0, 1);
        check("add.alu",   int'(alu_a), 2);
        check("add.state", int'(st_a),  S_RUN);

        // ---- ADDI, then NOP ----
        drive(1, 1'b1, 1'b0);
        tick();
        check_word("addi", 1, 1, 1, 1);
        check("addi.alu", int'(alu_a), 1);
        drive(0, 1'b1, 1'b0);
        tick();
        check_word("nop", 0, 0, 0, 1);
        check("nop.alu", int'(alu_a), 0);

        // ---- instr_valid low: default word, ALUFunc holds ----
        drive(3, 1'b0, 1'b0);
        tick();
        check_word("idle", 0, 0, 0, 1);
        check("idle.alu_hold", int'(alu_a), 0);

        // ---- LOAD with switch data ready in the same cycle ----
        drive(4, 1'b1, 1'b1);
        tick();
        check_word("ld_now", 1, 1, 0, 1);
        check("ld_now.state", int'(st_a), S_RUN);

        // ---- LOAD stalls: enter LDWAIT, 5 stall cycles, then sw_valid ----
        drive(4, 1'b1, 1'b0);
        tick();
        check("ld.enter_state", int'(st_a), S_LDWAIT);
        check("ld.enter_pc",    int'(pc_a), 0);
        check("ld.enter_cnt",   int'(cnt_a), 0);
        // Opcode 5 / instr_valid must be ignored while waiting.
        drive(5, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("ldw%0d.state", i), int'(st_a),  S_LDWAIT);
            check($sformatf("ldw%0d.pc", i),    int'(pc_a),  0);
            check($sformatf("ldw%0d.write", i), int'(wr_a),  0);
            check($sformatf("ldw%0d.cnt", i),   int'(cnt_a), i);
        end
        check("ldw.alu_hold", int'(alu_a), 0);
        drive(5, 1'b1, 1'b1);
        tick();
        check_word("ld_done", 1, 1, 0, 1);
        check("ld_done.state",   int'(st_a),  S_RUN);
        check("ld_done.cnt",     int'(cnt_a), 5);
        check("ld_done.cnt_sat", int'(cnt_b), 3);

        // ---- Illegal opcode 101 -> HALT, then HALT ignores ADD ----
        drive(5, 1'b1, 1'b0);
        tick();
        check("ill.illegal", int'(ill_a), 1);
        check("ill.state",   int'(st_a),  S_HALT);
        check("ill.pc",      int'(pc_a),  0);
        check("ill.write",   int'(wr_a),  0);
        check("ill.alu",     int'(alu_a), 1);
        drive(2, 1'b1, 1'b1);
        tick();
        tick();
        check("halt.state",   int'(st_a),  S_HALT);
        check("halt.illegal", int'(ill_a), 1);
        check("halt.pc",      int'(pc_a),  0);
        check("halt.write",   int'(wr_a),  0);
        check("halt.alu",     int'(alu_a), 1);

        // ---- Reset out of HALT ----
        reset = 1'b1;
        tick();
        check("hrst.illegal", int'(ill_a), 0);
        check("hrst.state",   int'(st_a),  S_RUN);
        check("hrst.cnt",     int'(cnt_a), 0);
        reset = 1'b0;

        // ---- MULI (011), build dependent ----
        drive(3, 1'b1, 1'b0);
        tick();
        check("muli.alu", int'(alu_a), 3);
`ifdef PICO_MULI_EN
        check_word("muli", 1, 1, 1, 1);
        check("muli.state", int'(st_a), S_RUN);
`else
        check_word("muli", 0, 0, 0, 0);
        check("muli.state",   int'(st_a),  S_HALT);
        check("muli.illegal", int'(ill_a), 1);
`endif

        // ---- Opcode 111 is illegal as well ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(7, 1'b1, 1'b0);
        tick();
        check("op7.state",   int'(st_a), S_HALT);
        check("op7.illegal", int'(ill_a), 1);

        // ---- Counter saturation (CNTW=2) and reset during LDWAIT ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(4, 1'b1, 1'b0);
        tick();
        check("sat.enter_state", int'(st_b), S_LDWAIT);
        drive(0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("sat.cnt_small", int'(cnt_b), 3);
        check("sat.cnt_wide",  int'(cnt_a), 6);
        check("sat.state",     int'(st_b),  S_LDWAIT);
        reset = 1'b1;
        tick();
        check("ldrst.state_small", int'(st_b),  S_RUN);
        check("ldrst.cnt_small",   int'(cnt_b), 0);
        check("ldrst.state_wide",  int'(st_a),  S_RUN);
        check("ldrst.cnt_wide",    int'(cnt_a), 0);
        check("ldrst.pc",          int'(pc_a),  0);
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
